// File: rtl/raster_pixel_streamer.sv
// Raster-ordered pixel source: pulls pixels over valid/ready, tags position and frame markers.
// Optional FRAME_COUNT_EN adds a 16-bit count of completed (non-aborted) frames.
module raster_pixel_streamer #(
  parameter int image_width   = 320,
  parameter int image_height  = 240,
  parameter int data_width    = 8,
  parameter int hblank_cycles = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [data_width-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [data_width-1:0]             pixel_out,
  output logic                              pixel_enable,
  output logic [$clog2(image_width)-1:0]    col,
  output logic [$clog2(image_height)-1:0]   row,
  output logic                              sof,
  output logic                              eol,
  output logic                              eof,
  output logic                              busy,
  output logic                              underrun
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]                       frame_count
`endif
);

  localparam int CW = $clog2(image_width);
  localparam int RW = $clog2(image_height);
  localparam int BW = (hblank_cycles > 1) ? $clog2(hblank_cycles) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_cnt;
  logic [BW-1:0]   blank_cnt;
  logic            accept, last_col, last_row, blank_done, start_frame;

  assign in_ready    = (state == ACTIVE);
  assign accept      = in_ready && in_valid && !abort;
  assign last_col    = (col_cnt == CW'(image_width - 1));
  assign last_row    = (row_cnt == RW'(image_height - 1));
  assign blank_done  = (blank_cnt == BW'(hblank_cycles - 1));
  // eof is registered while the state is already IDLE, so it keeps busy high and masks start
  assign start_frame = (state == IDLE) && start && !abort && !eof;
  assign busy        = (state != IDLE) || eof;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_frame) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (accept && last_col) begin
          if (last_row)                next_state = IDLE;
          else if (hblank_cycles == 0) next_state = ACTIVE;
          else                         next_state = HBLANK;
        end
      end
      HBLANK: begin
        if (abort)           next_state = IDLE;
        else if (blank_done) next_state = ACTIVE;
      end
      default: next_state = IDLE;
    endcase
  end

  // col_cnt/row_cnt point at the next pixel to accept; col/row report the emitted one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_out    <= '0;
      pixel_enable <= 1'b0;
      col          <= '0;
      row          <= '0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      underrun     <= 1'b0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      blank_cnt    <= '0;
    end else begin
      pixel_enable <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      if (start_frame) begin
        col_cnt  <= '0;
        row_cnt  <= '0;
        underrun <= 1'b0;
      end
      if (state == ACTIVE && !in_valid) underrun <= 1'b1;
      if (accept) begin
        pixel_out    <= in_data;
        pixel_enable <= 1'b1;
        col          <= col_cnt;
        row          <= row_cnt;
        sof          <= (col_cnt == '0) && (row_cnt == '0);
        eol          <= last_col;
        eof          <= last_col && last_row;
        if (last_col) begin
          col_cnt <= '0;
          if (!last_row) row_cnt <= row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (state != HBLANK)  blank_cnt <= '0;
      else if (!blank_done) blank_cnt <= blank_cnt + BW'(1);
    end
  end

`ifdef FRAME_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    frame_count <= '0;
    else if (eof) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_raster_pixel_streamer.sv
// Scoreboard bench for raster_pixel_streamer (4x3, hblank 2) plus a hblank=0 instance.
module tb_raster_pixel_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int HB = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start = 0, abort = 0, in_valid = 0, in_ready;
  logic [DW-1:0] in_data = '0, pixel_out;
  logic          pixel_enable, sof, eol, eof, busy, underrun;
  logic [1:0]    col, row;
  logic          start_nb = 0, abort_nb = 0, in_valid_nb = 0, in_ready_nb;
  logic [DW-1:0] in_data_nb = '0, pixel_out_nb;
  logic          pixel_enable_nb, sof_nb, eol_nb, eof_nb, busy_nb, underrun_nb;
  logic [1:0]    col_nb, row_nb;
`ifdef FRAME_COUNT_EN
  logic [15:0]   frame_count, frame_count_nb;
`endif

  raster_pixel_streamer #(.image_width(W), .image_height(H), .data_width(DW), .hblank_cycles(HB)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_out(pixel_out), .pixel_enable(pixel_enable),
    .col(col), .row(row), .sof(sof), .eol(eol), .eof(eof), .busy(busy), .underrun(underrun)
`ifdef FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  raster_pixel_streamer #(.image_width(W), .image_height(H), .data_width(DW), .hblank_cycles(0)) dut_nb (
    .clock(clock), .reset(reset), .start(start_nb), .abort(abort_nb), .in_data(in_data_nb),
    .in_valid(in_valid_nb), .in_ready(in_ready_nb), .pixel_out(pixel_out_nb), .pixel_enable(pixel_enable_nb),
    .col(col_nb), .row(row_nb), .sof(sof_nb), .eol(eol_nb), .eof(eof_nb), .busy(busy_nb), .underrun(underrun_nb)
`ifdef FRAME_COUNT_EN
    , .frame_count(frame_count_nb)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            c;
    int            r;
    logic          s;
    logic          e;
    logic          f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, failed = 0;
  int   mon_col = 0, mon_row = 0;

  // reference model: frame position by accepted-pixel count, blanking by cycles remaining
  bit   m_inframe = 0, m_eof_out = 0, m_underrun = 0;
  int   m_k = 0, m_blank = 0, m_fc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
    bit exp_ready, eof_next;
    @(negedge clock);
    start = s; abort = a; in_valid = v; in_data = d;
    exp_ready = m_inframe && (m_blank == 0);
    eof_next  = 0;
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("busy", busy, m_inframe || m_eof_out);
    checkOutput("underrun", underrun, m_underrun);
`ifdef FRAME_COUNT_EN
    checkOutput("frame_count", frame_count, m_fc);
`endif
    if (m_eof_out) m_fc++;
    if (m_inframe && a) begin
      if (exp_ready && !v) m_underrun = 1;
      m_inframe = 0;
    end else if (m_inframe) begin
      if (exp_ready) begin
        if (v) begin
          sb.push_back('{d, m_k % W, m_k / W, m_k == 0, (m_k % W) == W - 1, m_k == W * H - 1});
          if (m_k == W * H - 1) begin
            m_inframe = 0;
            eof_next  = 1;
          end else if (m_k % W == W - 1) begin
            m_blank = HB;
          end
          m_k++;
        end else begin
          m_underrun = 1;
        end
      end else begin
        m_blank--;
      end
    end else if (s && !a && !m_eof_out) begin
      m_inframe  = 1;
      m_k        = 0;
      m_blank    = 0;
      m_underrun = 0;
    end
    m_eof_out = eof_next;
  endtask

  // mode 0: valid always, data 0x10+k; mode 1: 3 stall cycles at row 1 col 2; mode 2: random
  task automatic runFrame(input int mode, input int abort_k);
    int lows = 0;
    int n = 0;
    bit v, a, s;
    logic [DW-1:0] d;
    applyStimulus(1, 0, 0, 0);
    while ((m_inframe || m_eof_out) && n < 200) begin
      v = 1; a = 0; s = 0;
      d = (mode == 0) ? DW'(8'h10 + m_k) : DW'($urandom);
      if (mode == 1 && m_k == 6 && m_blank == 0 && lows < 3) begin
        v = 0;
        lows++;
      end
      if (mode == 2) begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 4) == 0) || m_eof_out;
      end
      if (abort_k >= 0 && m_inframe && m_k == abort_k && m_blank == 0) a = 1;
      applyStimulus(s, a, v, d);
      n++;
    end
    checkOutput("frame_in_time", 32'(n < 200), 1);
    repeat (2) applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (pixel_enable) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_pixel", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pixel_out", pixel_out, mon_e.data);
          checkOutput("col", col, mon_e.c);
          checkOutput("row", row, mon_e.r);
          checkOutput("sof", sof, mon_e.s);
          checkOutput("eol", eol, mon_e.e);
          checkOutput("eof", eof, mon_e.f);
          mon_col = mon_e.c;
          mon_row = mon_e.r;
        end
      end else begin
        checkOutput("idle_flags", {sof, eol, eof}, 0);
        checkOutput("col_hold", col, mon_col);
        checkOutput("row_hold", row, mon_row);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pixel_out"}, pixel_out, 0);
    checkOutput({tag, "_pixel_enable"}, pixel_enable, 0);
    checkOutput({tag, "_col"}, col, 0);
    checkOutput({tag, "_row"}, row, 0);
    checkOutput({tag, "_flags"}, {sof, eol, eof}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_underrun"}, underrun, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
`ifdef FRAME_COUNT_EN
    checkOutput({tag, "_frame_count"}, frame_count, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    reset = 0;

    runFrame(0, -1);
    runFrame(1, -1);
    runFrame(0, 5);
    runFrame(0, -1);

    // asynchronous reset in the middle of row 0
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, DW'($urandom));
    #2 reset = 1;
    #1 checkResetValues("midreset");
    sb.delete();
    m_inframe = 0; m_eof_out = 0; m_underrun = 0; m_fc = 0;
    mon_col = 0; mon_row = 0;
    @(negedge clock);
    reset = 0;
    runFrame(0, -1);

    repeat (4) runFrame(2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1);

    // hblank_cycles=0 instance: 12 back-to-back pixels with in_ready never dropping
    @(negedge clock);
    start_nb = 1; in_valid_nb = 1;
    for (int i = 0; i < W * H; i++) begin
      @(negedge clock);
      start_nb   = 0;
      in_data_nb = DW'(8'h40 + i);
      checkOutput("nb_in_ready", in_ready_nb, 1);
      if (i > 0) begin
        checkOutput("nb_pixel_enable", pixel_enable_nb, 1);
        checkOutput("nb_pixel_out", pixel_out_nb, 8'h40 + i - 1);
        checkOutput("nb_col", col_nb, (i - 1) % W);
        checkOutput("nb_row", row_nb, (i - 1) / W);
        checkOutput("nb_eol", eol_nb, 32'(((i - 1) % W) == W - 1));
        checkOutput("nb_sof", sof_nb, 32'(i == 1));
      end
    end
    @(negedge clock);
    in_valid_nb = 0;
    checkOutput("nb_last_pixel", pixel_out_nb, 8'h40 + W * H - 1);
    checkOutput("nb_eof", {eof_nb, eol_nb}, 2'b11);
    checkOutput("nb_busy_eof", busy_nb, 1);
    checkOutput("nb_in_ready_done", in_ready_nb, 0);
    @(negedge clock);
    checkOutput("nb_busy_after", busy_nb, 0);
    checkOutput("nb_pixel_enable_after", pixel_enable_nb, 0);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/raster_pixel_streamer.md
Name: raster_pixel_streamer

Overview:
- Source end of the pixel pipeline. Pulls pixels from an upstream valid/ready source and emits a raster-ordered, enable-qualified pixel stream.
- pixel_enable drives the clock_enable of downstream line_buffer / window stages.
- Tracks column/row position, inserts fixed horizontal blanking between lines, and flags start-of-frame, end-of-line and end-of-frame.

Parameters:
- image_width, 320, active pixels per line (>=2)
- image_height, 240, lines per frame (>=2)
- data_width, 8, pixel bit width
- hblank_cycles, 4, idle cycles inserted after each line except the last (0 allowed)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame when idle
- abort  input  1  synchronous; terminates the current frame
- in_data  input  data_width  upstream pixel
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  streamer accepts in_data this cycle
- pixel_out  output  data_width  registered pixel to downstream
- pixel_enable  output  1  pixel_out valid this cycle (drives clock_enable)
- col  output  $clog2(image_width)  column of pixel_out
- row  output  $clog2(image_height)  row of pixel_out
- sof  output  1  with pixel (0,0)
- eol  output  1  with last pixel of each line
- eof  output  1  with last pixel of frame
- busy  output  1  frame in progress
- underrun  output  1  sticky; set when in_valid is low during ACTIVE; cleared by start

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: pixel_out, pixel_enable, col, row, sof, eol, eof, busy, underrun, in_ready.
- States: IDLE, ACTIVE, HBLANK.
- IDLE:
  - in_ready=0, busy=0.
  - start -> ACTIVE; internal column/row counters cleared; underrun cleared.
- ACTIVE:
  - in_ready=1 (combinational from state); busy=1.
  - Handshake in_valid&&in_ready: next cycle pixel_out=in_data and pixel_enable=1. col/row equal the position of that pixel. Latency is exactly 1 cycle.
  - sof/eol/eof are registered alongside pixel_enable and are high only in the cycle pixel_enable=1.
  - Cycle with in_valid=0: pixel_enable=0; pixel_out, col and row hold; underrun set. No downstream backpressure exists.
  - Accepted pixel at column image_width-1 asserts eol:
    - If it is not the last row: go to HBLANK, or directly to the next row's ACTIVE if hblank_cycles=0.
    - If it is the last row: also assert eof and go to IDLE. busy drops the cycle after eof.
- HBLANK:
  - in_ready=0, pixel_enable=0.
  - Blank counter runs hblank_cycles cycles, then ACTIVE with column=0 and row+1.
- Counter rules:
  - Column wraps image_width-1 -> 0.
  - Row increments only on line wrap.
  - No count ever reaches image_width or image_height.
- start while busy: ignored.
- abort (any state except IDLE):
  - Next cycle state=IDLE.
  - pixel_enable, sof, eol, eof forced 0.
  - Any pixel accepted in the abort cycle is dropped.
  - abort beats start in the same cycle.
- start and the eof cycle coincide: start is ignored (busy still high). A new frame needs start while IDLE.
- Reset mid-frame: immediate return to the reset values above.

Optional Feature:
- Macro FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments by 1, wrapping at 16 bits, in the cycle after eof.
  - Aborted frames are not counted.
- Undefined:
  - Port and logic absent; all other behaviour identical.

Test Plan (image_width=4, image_height=3, hblank_cycles=2):
- Reset asserted mid-ACTIVE -> all outputs 0 at once, state IDLE; start then yields sof with col=0,row=0.
- start, in_valid held 1, in_data=0x10..0x1B -> 12 pixel_enable pulses; eol at col=3 for rows 0,1,2; exactly 2 in_ready=0 cycles after each of row 0 and row 1; eof with pixel 0x1B; busy falls next cycle.
- in_valid low 3 cycles at row 1 col 2 -> pixel_enable 0 for those cycles, col/row hold, underrun=1 until next start; frame completes with 12 pixels total.
- hblank_cycles=0 build -> row 1 col 0 emitted the cycle after row 0 eol; in_ready never drops mid-frame.
- abort at row 1 col 1, then start -> no further pixel_enable from the first frame; the new frame begins with sof at (0,0); FRAME_COUNT_EN frame_count unchanged by the aborted frame, then 1 after the second frame's eof.
- start pulsed during ACTIVE and coincident with eof -> ignored; a start issued in IDLE begins the frame normally.
